// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_pkg
// Brief   : Geometry constants and word/address types for the sample SRAM.
// Revision: 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int SRAM_DEPTH  = 4096;
    localparam int SRAM_ADDR_W = 12;
    localparam int SRAM_DATA_W = 16;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_W-1:0] sram_word_t;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_sp_array.sv
`default_nettype none
// ============================================================================
// Module  : sram_sp_array
// Brief   : Storage array with a synchronous write port and combinational read.
// Revision: 1.0 - initial release
// ============================================================================
module sram_sp_array
    import sram_pkg::*;
#(
    parameter int DEPTH  = SRAM_DEPTH,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // No reset: contents persist across rst_n, like the hard macro.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule : sram_sp_array
`default_nettype wire

// File: rtl/sram_sp_4096x16.sv
`default_nettype none
// ============================================================================
// Module  : sram_sp_4096x16
// Brief   : Single-port sync SRAM, drop-in for SHAB90_4096X16X1CM16 (cs/web/oe).
// Revision: 1.0 - initial release
// ============================================================================
module sram_sp_4096x16
    import sram_pkg::*;
#(
    parameter int DEPTH  = SRAM_DEPTH,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout,
    input  logic              web,
    input  logic              cs,
    input  logic              oe
);

    logic              w_in_range;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    // A full power-of-two array makes every address legal, so skip the compare.
    generate
        if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
            assign w_in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];
            assign w_in_range = ({1'b0, a} < c_depth);
        end
    endgenerate

    assign w_we = rst_n & cs & ~web & w_in_range;

    sram_sp_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .addr  (a),
        .wdata (di),
        .rdata (w_rdata)
    );

    always_comb begin
        dout_d = dout_q;
        if (cs) begin
            if (!web) begin
                dout_d = di;
            end else begin
                dout_d = w_in_range ? w_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = oe ? dout_q : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && $isunknown({web, cs})) begin
            $warning("sram_sp_4096x16: web/cs unknown while out of reset");
        end
    end
`endif

endmodule : sram_sp_4096x16
`default_nettype wire

// File: tb/tb_sram_sp_4096x16.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_sp_4096x16
// Brief   : Directed, table-driven self-checking bench for sram_sp_4096x16.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_sp_4096x16;

    localparam int c_aw = 12;
    localparam int c_dw = 16;

    logic            clk;
    logic            rst_n;
    logic [c_aw-1:0] a;
    logic [c_dw-1:0] di;
    logic [c_dw-1:0] dout;
    logic            web;
    logic            cs;
    logic            oe;

    int n_tests;
    int n_fail;

    typedef struct {
        string           name;
        logic            rst_n;
        logic            cs;
        logic            web;
        logic            oe;
        logic [c_aw-1:0] a;
        logic [c_dw-1:0] di;
        logic [c_dw-1:0] exp;
    } vec_t;

    vec_t vecs [14];

    sram_sp_4096x16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .di    (di),
        .dout  (dout),
        .web   (web),
        .cs    (cs),
        .oe    (oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_dw-1:0] pattern(input logic [c_aw-1:0] addr);
        return {addr[7:0], ~addr[7:0]};
    endfunction

    task automatic check(input string name, input logic [c_dw-1:0] exp);
        n_tests++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL %s: dout=%h expected=%h", name, dout, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, return 1 ns after the rising edge.
    task automatic cycle(input logic r, input logic c, input logic w, input logic o,
                         input logic [c_aw-1:0] ad, input logic [c_dw-1:0] d);
        @(negedge clk);
        rst_n = r; cs = c; web = w; oe = o; a = ad; di = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; cs = 1'b1; web = 1'b0; oe = 1'b1; a = 12'd5; di = 16'hAAAA;

        vecs[0]  = '{"wt_write10",   1'b1, 1'b1, 1'b0, 1'b1, 12'd10,   16'h1234, 16'h1234};
        vecs[1]  = '{"wt_read10",    1'b1, 1'b1, 1'b1, 1'b1, 12'd10,   16'h0000, 16'h1234};
        vecs[2]  = '{"cs0_hold",     1'b1, 1'b0, 1'b0, 1'b1, 12'd10,   16'hFFFF, 16'h1234};
        vecs[3]  = '{"cs0_nowrite",  1'b1, 1'b1, 1'b1, 1'b1, 12'd10,   16'h0000, 16'h1234};
        vecs[4]  = '{"write20",      1'b1, 1'b1, 1'b0, 1'b1, 12'd20,   16'h5A5A, 16'h5A5A};
        vecs[5]  = '{"read0_bound",  1'b1, 1'b1, 1'b1, 1'b1, 12'd0,    16'h0000, 16'h00FF};
        vecs[6]  = '{"read20",       1'b1, 1'b1, 1'b1, 1'b1, 12'd20,   16'h0000, 16'h5A5A};
        vecs[7]  = '{"oe0_gate",     1'b1, 1'b0, 1'b1, 1'b0, 12'd0,    16'h0000, 16'h0000};
        vecs[8]  = '{"oe1_cs0",      1'b1, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0000, 16'h5A5A};
        vecs[9]  = '{"write7",       1'b1, 1'b1, 1'b0, 1'b1, 12'd7,    16'hBEEF, 16'hBEEF};
        vecs[10] = '{"mid_reset",    1'b0, 1'b1, 1'b1, 1'b1, 12'd7,    16'h0000, 16'h0000};
        vecs[11] = '{"read7_persist",1'b1, 1'b1, 1'b1, 1'b1, 12'd7,    16'h0000, 16'hBEEF};
        vecs[12] = '{"read4095",     1'b1, 1'b1, 1'b1, 1'b1, 12'd4095, 16'h0000, 16'hFF00};
        vecs[13] = '{"cs0_rd_hold",  1'b1, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0000, 16'hFF00};

        // Reset held two cycles with a write pending: nothing may land.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 12'd5, 16'hAAAA);
        check("reset_cyc1", 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 12'd5, 16'hAAAA);
        check("reset_cyc2", 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'd5, 16'h0000);
        n_tests++;
        if (dout === 16'hAAAA) begin
            n_fail++;
            $display("FAIL reset_suppress_write: dout=%h must not be aaaa", dout);
        end

        for (int i = 0; i < 4096; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, i[c_aw-1:0], pattern(i[c_aw-1:0]));
            check("fill_writethrough", pattern(i[c_aw-1:0]));
        end
        for (int i = 0; i < 4096; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, i[c_aw-1:0], 16'h0000);
            check("readback", pattern(i[c_aw-1:0]));
        end

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rst_n, vecs[i].cs, vecs[i].web, vecs[i].oe, vecs[i].a, vecs[i].di);
            check(vecs[i].name, vecs[i].exp);
        end

        // oe gating is combinational: observe it between clock edges.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'd20, 16'h0000);
        check("oe_pre_read", 16'h5A5A);
        @(negedge clk);
        cs = 1'b0;
        oe = 1'b0;
        #1;
        check("oe_drop_immediate", 16'h0000);
        oe = 1'b1;
        #1;
        check("oe_raise_immediate", 16'h5A5A);

        // Write then read the same address on consecutive edges.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 12'd300, 16'hC3C3);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'd301, 16'h0000);
        check("neighbour_untouched", pattern(12'd301));
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'd300, 16'h0000);
        check("write_then_read", 16'hC3C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sram_sp_4096x16
`default_nettype wire

// File: doc/sram_sp_4096x16.md
Name: sram_sp_4096x16

Overview:
- Single-port synchronous SRAM, 4096 words x 16 bits.
- Behavioural and synthesizable equivalent of the SHAB90_4096X16X1CM16 macro.
- Serves as the point-sample store of the k-means accelerator:
  - input phase writes samples (x in [15:8], y in [7:0]) at sequential addresses;
  - clustering phase reads them back, one word per cycle.
- One address port shared by read and write, selected by active-low write enable; chip select and output enable as on the macro.

Parameters:
- DEPTH, 4096, number of words.
- ADDR_W, 12, address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 16, word width.

Ports:
- clk, input, 1, rising-edge clock (macro CK).
- rst_n, input, 1, synchronous active-low reset.
- a, input, ADDR_W, word address (macro A).
- di, input, DATA_W, write data (macro DI).
- dout, output, DATA_W, read data (macro DO).
- web, input, 1, write enable, active low: 0 = write, 1 = read (macro WEB).
- cs, input, 1, chip select, active high (macro CS).
- oe, input, 1, output enable, active high (macro OE).

Behaviour:
- All state changes on the rising edge of clk. The only combinational path is the oe gating of dout.
- Reset: rst_n low at a clk edge clears the output latch to 0 and suppresses any read or write that cycle. Array contents are NOT cleared; they persist across reset.
- Internal output latch dout_q, DATA_W bits:
  - oe=1: dout = dout_q.
  - oe=0: dout = 0 (no tri-state).
- Priority each edge: reset > cs=0 > write > read.
- cs=0: no access; array and dout_q hold.
- Write (cs=1, web=0): mem[a] <= di. Write-through: dout_q <= di in the same edge.
- Read (cs=1, web=1): dout_q <= mem[a]. Latency is 1 cycle: an address presented before edge N appears on dout after edge N. Back-to-back reads give one new word per cycle.
- Read of a never-written location returns X in simulation; no defined value is guaranteed.
- Address a >= DEPTH: writes ignored, reads load 0. Unreachable when DEPTH = 2**ADDR_W.
- Write followed by read of the same address on the next edge returns the new data; no extra hazard cycle.
- No internal pipelining beyond dout_q.
- No assertions on X inputs, except a simulation-only warning when web or cs is X while rst_n = 1.

Decomposition:
- Package sram_pkg: localparams SRAM_DEPTH=4096, SRAM_ADDR_W=12, SRAM_DATA_W=16, plus typedefs sram_addr_t and sram_word_t.
- Sub-module sram_sp_array holds the storage array and the write port (clk, we, addr, wdata, rdata, combinational read).
- Top sram_sp_4096x16 adds cs/web decode, reset handling, the dout_q latch, write-through and oe gating.

Test Plan:
- Reset: rst_n=0 for 2 cycles with cs=1, web=0, a=5, di=16'hAAAA -> dout=0. A subsequent read of address 5 returns X or the prior content, never 16'hAAAA.
- Sequential fill and readback:
  - write a=0..4095 with di = {a[7:0], ~a[7:0]};
  - read a=0..4095 back-to-back, cs=1, oe=1 -> dout equals the written pattern one cycle after each address, no bubbles.
  - Boundaries: a=4095 read returns 16'hFF00; a=0 read returns 16'h00FF.
- Write-through: cs=1, web=0, a=10, di=16'h1234 -> dout=16'h1234 after that edge. Next cycle, read a=10 -> 16'h1234.
- Chip select:
  - cs=0, web=0, a=10, di=16'hFFFF -> no write and dout holds;
  - then read a=10 -> 16'h1234.
- Output enable: after a read of a word holding 16'h5A5A, drop oe=0 -> dout=0 immediately. Raise oe=1 with cs=0 -> dout=16'h5A5A.
- Reset mid-operation:
  - write a=7, di=16'hBEEF;
  - pulse rst_n low for 1 cycle -> dout=0;
  - read a=7 -> 16'hBEEF, showing contents survive reset.
